ram_to_vga: RTL
===============

Name: ram_to_vga

Overview:
Frame-buffer scan-out stage, directly downstream of the ROM-to-RAM copy stage. Generates 640x480@60 VGA timing from a 25 MHz pixel clock. Reads the 8-bit grayscale image the copy stage wrote into dual-port RAM: 160x120 native, or 320x240 when the 2x scale is selected. Centres the image on screen, paints the border black, and drives sync and RGB outputs that are aligned to the pixel data.

Parameters:
LARGURA, 160, source image width in pixels
ALTURA, 120, source image height in pixels
FATOR, 2, upscale factor used when switch=1
H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel clocks
V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
clk  in  1  pixel clock, 25 MHz
reset  in  1  synchronous, active-low reset
switch  in  1  image-size select: 0 = LARGURA x ALTURA, 1 = scaled by FATOR; same meaning as in the copy stage
start  in  1  copy-stage done flag; high means RAM content is valid
ram_rdaddr  out  19  RAM read address, row-major, stride = current width
ram_q  in  8  RAM read data, valid 1 clk after ram_rdaddr
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_blank_n  out  1  high during the visible 640x480 area
vga_r/vga_g/vga_b  out  8 each  pixel colour; grayscale replicated on all three
frame_tick  out  1  one-clk pulse, aligned with the output of pixel (0,0)

Behaviour:
- Reset, sampled on the clk edge while reset=0:
  - h_cnt = 0, v_cnt = 0, state = IDLE.
  - ram_rdaddr = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0, rgb = 0, frame_tick = 0.
  - All pipeline registers cleared.
- Timing counters:
  - h_cnt runs 0..799, then wraps to 0.
  - v_cnt increments on each h_cnt wrap and runs 0..524, then wraps to 0.
  - Counters run in every state.
  - hs is low for h in [656,751]; vs is low for v in [490,491]; visible area is h<640 and v<480.
- Geometry is latched at frame start (h=0, v=0) only, so a switch change mid-frame takes effect on the next frame:
  - w = switch ? LARGURA*FATOR : LARGURA
  - ht = switch ? ALTURA*FATOR : ALTURA
  - x0 = (640-w)/2
  - y0 = (480-ht)/2
- In-image condition: x0 <= h < x0+w and y0 <= v < y0+ht.
- Address: ram_rdaddr = (v-y0)*w + (h-x0) when in-image, else 0. Computed to 19 bits with no truncation; maximum value 76799.
- Pipeline, for a counter position (h,v) at cycle t:
  - t+1: ram_rdaddr is registered, and in_img is delayed into stage 1.
  - t+2: ram_q is valid.
  - t+3: rgb, hs, vs, blank_n and frame_tick are registered outputs.
  - Total latency is 3 clks; all outputs go through the same 3-stage delay so they stay mutually aligned.
- Output colour: rgb = {ram_q, ram_q, ram_q} when state = SHOW and delayed in_img = 1; otherwise rgb = 0, including during blanking.
- FSM:
  - IDLE: rgb forced to 0, sync still runs. Go to ARM when start = 1.
  - ARM: rgb forced to 0. Go to SHOW at the next frame start (h=0, v=0), so there is never a torn first frame.
  - SHOW: normal scan-out. Return to IDLE on the same cycle start goes to 0, with no frame-boundary wait.
- start dropping mid-frame: rgb is 0 from the third output cycle onward; sync is unaffected.
- start re-asserting: display resumes only at the next frame boundary.
- frame_tick: one pulse per frame (every 420000 clks), in every state.

Test Plan:
- Release reset, run 2 frames -> hs period 800 clks, low 96; vs period 525 lines, low 2 lines. First hs falling edge appears at output cycle 656+3.
- switch=0, start=1 held, RAM filled with addr[7:0] -> in SHOW:
  - h=240, v=180 gives ram_rdaddr=0 at t+1 and rgb=0x000000 at t+3.
  - h=399, v=299 gives ram_rdaddr=19199.
  - h=239 and h=400 give rgb=0.
- switch=1 -> x0=160, y0=120. h=160, v=120 gives addr 0; h=479, v=359 gives addr 76799; h=161, v=121 gives addr 321.
- Toggle switch at v=200 -> current frame keeps its old geometry; next frame uses the new x0/y0.
- start low -> rgb stays 0 for a whole frame. Raise start mid-frame -> rgb stays 0 until the frame_tick that follows the next frame start. Drop start in SHOW -> rgb is 0 within 3 clks.
- Assert reset (=0) mid-line at h=300 -> next cycle all outputs hold reset values; after release, counting restarts from h=0, v=0.

Source files
------------

// File: rtl/ram_to_vga.sv
// Frame-buffer scan-out: 640x480@60 VGA timing, centred grayscale image read
// from dual-port RAM, all outputs delayed 3 clks to line up with RAM data.
module ram_to_vga #(
    parameter int unsigned LARGURA = 160,
    parameter int unsigned ALTURA  = 120,
    parameter int unsigned FATOR   = 2,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        switch,
    input  logic        start,
    output logic [18:0] ram_rdaddr,
    input  logic [7:0]  ram_q,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_tick
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned CW      = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
    localparam int unsigned AW      = 19;

    // Native and scaled image geometry, centred in the visible area
    localparam int unsigned W0  = LARGURA;
    localparam int unsigned W1  = LARGURA * FATOR;
    localparam int unsigned HT0 = ALTURA;
    localparam int unsigned HT1 = ALTURA * FATOR;
    localparam int unsigned X00 = (H_VIS - W0) / 2;
    localparam int unsigned X01 = (H_VIS - W1) / 2;
    localparam int unsigned Y00 = (V_VIS - HT0) / 2;
    localparam int unsigned Y01 = (V_VIS - HT1) / 2;

    typedef enum logic [1:0] {IDLE, ARM, SHOW} state_t;

    state_t        state, state_next;
    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_last, v_last, frame_start;
    logic          geo_sw;
    logic [CW-1:0] cur_w, x0, x1, y0, y1;
    logic          in_img, show, pix_on;
    logic [AW-1:0] addr;
    logic          hs_now, vs_now, blank_now;

    logic          pix1, hs1, vs1, blank1, tick1;
    logic          pix2, hs2, vs2, blank2, tick2;

    assign h_last      = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last      = (v_cnt == CW'(V_TOTAL - 1));
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);

    // Free-running raster counters, independent of FSM state
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    // Image size is sampled only at frame start so a frame is never mixed
    always_ff @(posedge clk) begin
        if (!reset) begin
            geo_sw <= 1'b0;
        end else if (frame_start) begin
            geo_sw <= switch;
        end
    end

    assign cur_w = geo_sw ? CW'(W1)        : CW'(W0);
    assign x0    = geo_sw ? CW'(X01)       : CW'(X00);
    assign x1    = geo_sw ? CW'(X01 + W1)  : CW'(X00 + W0);
    assign y0    = geo_sw ? CW'(Y01)       : CW'(Y00);
    assign y1    = geo_sw ? CW'(Y01 + HT1) : CW'(Y00 + HT0);

    assign in_img    = (h_cnt >= x0) && (h_cnt < x1) && (v_cnt >= y0) && (v_cnt < y1);
    assign addr      = in_img ? (AW'(v_cnt - y0) * AW'(cur_w) + AW'(h_cnt - x0)) : '0;
    assign hs_now    = !((h_cnt >= CW'(H_VIS + H_FP)) && (h_cnt < CW'(H_VIS + H_FP + H_SYNC)));
    assign vs_now    = !((v_cnt >= CW'(V_VIS + V_FP)) && (v_cnt < CW'(V_VIS + V_FP + V_SYNC)));
    assign blank_now = (h_cnt < CW'(H_VIS)) && (v_cnt < CW'(V_VIS));

    // Losing start blanks the picture immediately, not at the frame boundary
    assign show   = (state == SHOW) && start;
    assign pix_on = show && in_img;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: display only begins on a frame boundary
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = ARM;
            ARM: begin
                if (!start) begin
                    state_next = IDLE;
                end else if (frame_start) begin
                    state_next = SHOW;
                end
            end
            SHOW: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: RAM address out, sync/pixel flags follow
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_rdaddr <= '0;
            pix1       <= 1'b0;
            hs1        <= 1'b1;
            vs1        <= 1'b1;
            blank1     <= 1'b0;
            tick1      <= 1'b0;
        end else begin
            ram_rdaddr <= addr;
            pix1       <= pix_on;
            hs1        <= hs_now;
            vs1        <= vs_now;
            blank1     <= blank_now;
            tick1      <= frame_start;
        end
    end

    // Stage 2: wait for RAM read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix2   <= 1'b0;
            hs2    <= 1'b1;
            vs2    <= 1'b1;
            blank2 <= 1'b0;
            tick2  <= 1'b0;
        end else begin
            pix2   <= pix1;
            hs2    <= hs1;
            vs2    <= vs1;
            blank2 <= blank1;
            tick2  <= tick1;
        end
    end

    // Stage 3: registered VGA outputs aligned with ram_q
    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_tick  <= 1'b0;
        end else begin
            vga_hs      <= hs2;
            vga_vs      <= vs2;
            vga_blank_n <= blank2;
            vga_r       <= pix2 ? ram_q : 8'h00;
            vga_g       <= pix2 ? ram_q : 8'h00;
            vga_b       <= pix2 ? ram_q : 8'h00;
            frame_tick  <= tick2;
        end
    end

endmodule
